// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem word request at a time,
// applies trap/branch redirects and buffers a word across stalls. Macro: FETCH_MISALIGN_EXC_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_add4_o,
  output logic [31:0] inst_o,
  output logic        exc_addr_o,
  output logic        ready_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
`ifdef FETCH_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam logic [XLEN-1:0] RESET_PC = MIS_EN ? RESET_ADDR : {RESET_ADDR[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    return MIS_EN && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return MIS_EN ? a : {a[XLEN-1:2], 2'b00};
  endfunction

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_req, w_req_nxt;
  logic            r_exc_sent, w_exc_sent_nxt;
  logic [XLEN-1:0] r_buf_pc, w_buf_pc_nxt;
  logic [XLEN-1:0] r_buf_inst, w_buf_inst_nxt;
  logic            r_buf_exc, w_buf_exc_nxt;
  logic [XLEN-1:0] r_pc_o, w_pc_o_nxt;
  logic [XLEN-1:0] r_pc_add4, w_pc_add4_nxt;
  logic [XLEN-1:0] r_inst, w_inst_nxt;
  logic            r_exc, w_exc_nxt;
  logic            r_ready, w_ready_nxt;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_mis;
  logic            w_mem_ack;
  logic            w_fetch_ack;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_pc_step;
  logic [XLEN-1:0] w_kill_pc;

  // Once a misaligned fetch has been reported only a trap may move the PC.
  assign w_redir     = trap_i | (branch_i & ~r_exc_sent);
  assign w_target    = align_pc(trap_i ? trap_addr_i : branch_target_i);
  assign w_mis       = is_misaligned(r_pc);
  assign w_mem_ack   = r_req & imem_ack_i;
  assign w_fetch_ack = w_mis ? ~r_exc_sent : w_mem_ack;
  assign w_word      = w_mis ? NOP_INST : imem_data_i;
  assign w_pc_step   = w_mis ? r_pc : r_pc + PC_STEP;
  assign w_kill_pc   = w_redir ? w_target : r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_exc_sent <= 1'b0;
      r_buf_pc   <= '0;
      r_buf_inst <= NOP_INST;
      r_buf_exc  <= 1'b0;
      r_pc_o     <= '0;
      r_pc_add4  <= '0;
      r_inst     <= NOP_INST;
      r_exc      <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
      r_exc_sent <= w_exc_sent_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_buf_exc  <= w_buf_exc_nxt;
      r_pc_o     <= w_pc_o_nxt;
      r_pc_add4  <= w_pc_add4_nxt;
      r_inst     <= w_inst_nxt;
      r_exc      <= w_exc_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_addr_nxt     = r_addr;
    w_req_nxt      = r_req;
    w_exc_sent_nxt = r_exc_sent;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_buf_exc_nxt  = r_buf_exc;
    w_pc_o_nxt     = r_pc_o;
    w_pc_add4_nxt  = r_pc_add4;
    w_inst_nxt     = r_inst;
    w_exc_nxt      = r_exc;
    w_ready_nxt    = 1'b0;

    unique case (r_state)
      ST_FETCH: begin
        if (w_redir) begin
          w_pc_nxt       = w_target;
          w_exc_sent_nxt = 1'b0;
          if (r_req && !imem_ack_i) begin
            // Request in flight: address must stay put until memory answers.
            w_state_nxt = ST_KILL;
          end else begin
            w_addr_nxt = w_target;
            w_req_nxt  = ~is_misaligned(w_target);
          end
        end else if (w_fetch_ack) begin
          w_pc_nxt       = w_pc_step;
          w_exc_sent_nxt = w_mis;
          if (!stall_i) begin
            w_pc_o_nxt    = r_pc;
            w_pc_add4_nxt = r_pc + PC_STEP;
            w_inst_nxt    = w_word;
            w_exc_nxt     = w_mis;
            w_ready_nxt   = 1'b1;
            w_addr_nxt    = w_pc_step;
            w_req_nxt     = ~w_mis;
          end else begin
            w_buf_pc_nxt   = r_pc;
            w_buf_inst_nxt = w_word;
            w_buf_exc_nxt  = w_mis;
            w_req_nxt      = 1'b0;
            w_state_nxt    = ST_HOLD;
          end
        end else begin
          // Idle in FETCH (e.g. just out of reset): launch the request for the PC.
          w_addr_nxt = r_pc;
          w_req_nxt  = ~w_mis;
        end
      end

      ST_HOLD: begin
        if (w_redir) begin
          w_pc_nxt       = w_target;
          w_exc_sent_nxt = 1'b0;
          w_addr_nxt     = w_target;
          w_req_nxt      = ~is_misaligned(w_target);
          w_state_nxt    = ST_FETCH;
        end else if (!stall_i) begin
          w_pc_o_nxt    = r_buf_pc;
          w_pc_add4_nxt = r_buf_pc + PC_STEP;
          w_inst_nxt    = r_buf_inst;
          w_exc_nxt     = r_buf_exc;
          w_ready_nxt   = 1'b1;
          w_addr_nxt    = r_pc;
          w_req_nxt     = ~is_misaligned(r_pc);
          w_state_nxt   = ST_FETCH;
        end
      end

      ST_KILL: begin
        w_pc_nxt = w_kill_pc;
        if (w_redir) begin
          w_exc_sent_nxt = 1'b0;
        end
        if (w_mem_ack) begin
          w_addr_nxt  = w_kill_pc;
          w_req_nxt   = ~is_misaligned(w_kill_pc);
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign pc_o        = r_pc_o;
  assign pc_add4_o   = r_pc_add4;
  assign inst_o      = r_inst;
  assign exc_addr_o  = MIS_EN & r_exc;
  assign ready_o     = r_ready;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model acks requests, delivered words are
// queued as expectations and popped when ready_o fires.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0033;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        trap_i;
  logic [31:0] trap_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] pc_add4_o;
  logic [31:0] inst_o;
  logic        exc_addr_o;
  logic        ready_o;

  fetch_unit #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_addr_i     (trap_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .pc_add4_o       (pc_add4_o),
    .inst_o          (inst_o),
    .exc_addr_o      (exc_addr_o),
    .ready_o         (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_errors;
  int          n_pop;
  logic [31:0] m_pc;
  logic        kill_pend;
  logic        prev_pending;
  logic [31:0] prev_addr;
  logic        exp_ready;
  int          age;
  int          cur_lat;
  int          lat;
  logic        rand_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 ^ (a << 7);
  endfunction

  function automatic logic [31:0] model_align(input logic [31:0] a);
`ifdef FETCH_MISALIGN_EXC_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic reset_model();
    sb.delete();
    m_pc         = model_align(RESET_ADDR);
    kill_pend    = 1'b0;
    prev_pending = 1'b0;
    prev_addr    = '0;
    exp_ready    = 1'b0;
    age          = 0;
    cur_lat      = 0;
  endtask

  // Called #1 after a rising edge: checks this cycle's outputs, drives inputs, advances one cycle.
  task automatic cycle(input logic stall, input logic br, input logic [31:0] bt,
                       input logic tr, input logic [31:0] ta);
    logic        ack;
    logic        redir;
    logic [31:0] tgt;
    exp_t        e;
    check("ready", 32'(ready_o), 32'(exp_ready));
    if (ready_o) begin
      check("sb_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        check("pc", pc_o, e.pc);
        check("pc_add4", pc_add4_o, e.pc + 32'd4);
        check("inst", inst_o, e.inst);
        check("exc", 32'(exc_addr_o), 32'(e.exc));
      end
    end
    if (prev_pending) begin
      check("req_hold", 32'(imem_req_o), 32'd1);
      check("addr_hold", imem_addr_o, prev_addr);
    end else if (imem_req_o) begin
      check("req_addr", imem_addr_o, m_pc);
      age     = 0;
      cur_lat = rand_lat ? int'($urandom_range(0, 2)) : lat;
    end
    ack = imem_req_o && (age >= cur_lat);

    stall_i         = stall;
    branch_i        = br;
    branch_target_i = bt;
    trap_i          = tr;
    trap_addr_i     = ta;
    imem_ack_i      = ack;
    imem_data_i     = ack ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

    redir = tr | br;
    tgt   = model_align(tr ? ta : bt);
    if (ack) begin
      if (kill_pend || redir) begin
        kill_pend = 1'b0;
      end else begin
        sb.push_back('{pc: imem_addr_o, inst: mem_word(imem_addr_o), exc: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (redir) begin
      sb.delete();
      m_pc = tgt;
      if (imem_req_o && !ack) kill_pend = 1'b1;
    end
    prev_pending = imem_req_o && !ack;
    prev_addr    = imem_addr_o;
    if (imem_req_o && !ack) age++;
    exp_ready = !stall && !redir && (sb.size() != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wait_fresh(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 12 && !(imem_req_o && !prev_pending); i++) idle();
    check({tag, "_req"}, 32'(imem_req_o && !prev_pending), 32'd1);
    check({tag, "_addr"}, imem_addr_o, addr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pop    = 0;
    lat      = 0;
    rand_lat = 1'b0;
    rst             = 1'b0;
    stall_i         = 1'b0;
    branch_i        = 1'b0;
    branch_target_i = '0;
    trap_i          = 1'b0;
    trap_addr_i     = '0;
    imem_ack_i      = 1'b0;
    imem_data_i     = '0;
    reset_model();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", inst_o, NOP);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_pc4", pc_add4_o, 32'd0);
    check("rst_exc", 32'(exc_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, RESET_ADDR);

    // Zero-wait stream, then a 3-cycle stall landing on the ack at PC 8
    idle();
    idle();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("hold_noreq", 32'(imem_req_o), 32'd0);
      check("hold_pc", pc_o, 32'h4);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    check("hold_noreq", 32'(imem_req_o), 32'd0);
    idle();
    check("release_pc", pc_o, 32'h8);
    check("release_next", imem_addr_o, 32'hC);
    repeat (4) idle();

    // Branch while a request at 0x10 is still waiting
    lat = 2;
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    wait_fresh("to_10", 32'h10);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("kill_addr", imem_addr_o, 32'h10);
    wait_fresh("to_40", 32'h40);
    lat = 0;
    repeat (3) idle();

    // Trap and branch together: trap wins
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h200);
    wait_fresh("trap_prio", 32'h200);
    repeat (3) idle();

    // Misaligned branch target
    cycle(1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_EXC_EN
    sb.push_back('{pc: 32'h42, inst: NOP, exc: 1'b1});
    for (int i = 0; i < 4; i++) begin
      check("mis_noreq", 32'(imem_req_o), 32'd0);
      idle();
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    wait_fresh("mis_trap", 32'h100);
`else
    wait_fresh("align", 32'h40);
`endif
    repeat (3) idle();

    // Reset in the middle of an outstanding request
    lat = 3;
    idle();
    idle();
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_inst", inst_o, NOP);
    reset_model();
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_req", 32'(imem_req_o), 32'd1);
    check("rerst_addr", imem_addr_o, RESET_ADDR);

    // Random stalls, latencies and redirects
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cycle(($urandom_range(0, 3) == 0), (r < 6), 32'($urandom_range(0, 255)) << 2,
            (r >= 97), 32'($urandom_range(0, 255)) << 2);
    end
    rand_lat = 1'b0;
    repeat (8) idle();
    check("pops_seen", 32'(n_pop > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
